// File: rtl/udc_pkg.sv
// Shared types and the step function for the two-port up/down counter arbiter.
package udc_pkg;
  localparam int UDC_WIDTH = 16;
  localparam int UDC_LEN_W = 8;
  localparam int NUM_PORTS = 2;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  // Operates on a 32-bit container so any WIDTH <= 32 can share it; max is all-ones at WIDTH.
  function automatic logic [31:0] next_count(logic [31:0] cnt, logic [31:0] max,
                                             logic up, logic sat);
    if (up) return (cnt == max) ? (sat ? cnt : 32'd0) : cnt + 32'd1;
    else    return (cnt == 32'd0) ? (sat ? cnt : max) : cnt - 32'd1;
  endfunction
endpackage

// File: rtl/udc_if.sv
// Per-port command handshake between requesters and the arbiter.
interface udc_if #(parameter int LEN_W = 8);
  logic [1:0]         req_valid;
  logic [1:0]         req_ready;
  logic [1:0]         req_up;
  logic [2*LEN_W-1:0] req_len;

  modport master (output req_valid, req_up, req_len, input req_ready);
  modport slave  (input req_valid, req_up, req_len, output req_ready);
endinterface

// File: rtl/udc_core.sv
// Counter register: steps once per enabled cycle, saturating or wrapping.
module udc_core
  import udc_pkg::*;
#(
  parameter int WIDTH = UDC_WIDTH,
  parameter bit SAT   = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up,
  output logic [WIDTH-1:0] counter,
  output logic             blocked
);
  assign blocked = en && SAT && (up ? (counter == {WIDTH{1'b1}}) : (counter == '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  counter <= '0;
    else if (en) counter <= WIDTH'(next_count(32'(counter), 32'({WIDTH{1'b1}}), up, SAT));
  end
endmodule

// File: rtl/udc_arbiter.sv
// Round-robin owner of the shared counter: arbitrates, runs len steps, pulses done.
module udc_arbiter
  import udc_pkg::*;
#(
  parameter int WIDTH = UDC_WIDTH,
  parameter int LEN_W = UDC_LEN_W,
  parameter bit SAT   = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  udc_if.slave             req,
  output logic [WIDTH-1:0] counter,
  output logic             busy,
  output logic             grant_id,
  output logic             done,
  output logic             done_id,
  output logic             clipped
);
  state_t             state;
  logic [LEN_W-1:0]   remaining;
  logic               dir, clip, last, win, accept, blocked;
  logic [LEN_W-1:0]   win_len;

  // With both ports asking, the one not served last time goes first.
  assign win     = (&req.req_valid) ? ~last : req.req_valid[1];
  assign accept  = (state == IDLE) && (|req.req_valid);
  assign win_len = win ? req.req_len[2*LEN_W-1:LEN_W] : req.req_len[LEN_W-1:0];

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_rdy
    assign req.req_ready[i] = accept && (win == 1'(i));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      remaining <= '0;
      dir       <= 1'b0;
      clip      <= 1'b0;
      grant_id  <= 1'b0;
      last      <= 1'b1;
    end else begin
      case (state)
        IDLE: if (accept) begin
          dir      <= req.req_up[win];
          grant_id <= win;
          last     <= win;
          clip     <= 1'b0;
          if (win_len != '0) begin
            state     <= RUN;
            remaining <= win_len;
          end else begin
            state <= DONE;
          end
        end
        RUN: begin
          remaining <= remaining - LEN_W'(1);
          if (blocked) clip <= 1'b1;
          if (remaining == LEN_W'(1)) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  udc_core #(.WIDTH(WIDTH), .SAT(SAT)) u_core (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (state == RUN),
    .up      (dir),
    .counter (counter),
    .blocked (blocked)
  );

  assign busy    = (state != IDLE);
  assign done    = (state == DONE);
  assign done_id = grant_id;
  assign clipped = clip;
endmodule

// File: tb/tb_udc_arbiter.sv
// Directed bench: saturating (a) and wrapping (b) instances driven with identical commands.
module tb_udc_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  udc_if #(.LEN_W(8)) ia ();
  udc_if #(.LEN_W(8)) ib ();

  logic [15:0] cnt_a, cnt_b;
  logic        busy_a, gid_a, done_a, did_a, clip_a;
  logic        busy_b, gid_b, done_b, did_b, clip_b;

  udc_arbiter #(.WIDTH(16), .LEN_W(8), .SAT(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .req(ia), .counter(cnt_a), .busy(busy_a),
    .grant_id(gid_a), .done(done_a), .done_id(did_a), .clipped(clip_a));

  udc_arbiter #(.WIDTH(16), .LEN_W(8), .SAT(1'b0)) dut_w (
    .clk(clk), .rst_n(rst_n), .req(ib), .counter(cnt_b), .busy(busy_b),
    .grant_id(gid_b), .done(done_b), .done_id(did_b), .clipped(clip_b));

  int checks = 0;
  int failures = 0;
  int ndone = 0;

  always @(negedge clk) if (done_a) ndone++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input int p, input bit v, input bit up, input logic [7:0] len);
    ia.req_valid[p] = v;  ib.req_valid[p] = v;
    ia.req_up[p]    = up; ib.req_up[p]    = up;
    ia.req_len[p*8 +: 8] = len;
    ib.req_len[p*8 +: 8] = len;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
  endtask

  initial begin
    ia.req_valid = '0; ia.req_up = '0; ia.req_len = '0;
    ib.req_valid = '0; ib.req_up = '0; ib.req_len = '0;

    // reset with no requests
    tick(2);
    rst_n = 1'b1;
    tick(3);
    chk("rst_counter", cnt_a, 16'h0000);
    chk("rst_busy", busy_a, 0);
    chk("rst_ready", ia.req_ready, 2'b00);
    chk("rst_grant", gid_a, 0);
    chk("rst_no_done", ndone, 0);

    // single port: p0 up 7
    drive(0, 1, 1, 8'd7);
    #1 chk("single_ready", ia.req_ready, 2'b01);
    tick(1);
    drive(0, 0, 1, 8'd7);
    chk("single_ready_run", ia.req_ready, 2'b00);
    chk("single_busy", busy_a, 1);
    chk("single_cnt0", cnt_a, 0);
    for (int k = 1; k <= 7; k++) begin
      tick(1);
      chk($sformatf("single_cnt%0d", k), cnt_a, k);
    end
    chk("single_done", done_a, 1);
    chk("single_done_id", did_a, 0);
    chk("single_clipped", clip_a, 0);
    chk("single_ready_done", ia.req_ready, 2'b00);
    tick(1);
    chk("single_busy_low", busy_a, 0);
    chk("single_done_low", done_a, 0);
    chk("single_ndone", ndone, 1);

    // contention: p0 up 5 and p1 down 3; p0 re-requests and must yield to p1
    do_reset();
    drive(0, 1, 1, 8'd5);
    drive(1, 1, 0, 8'd3);
    #1 chk("cont_ready_p0", ia.req_ready, 2'b01);
    tick(1);
    drive(0, 1, 1, 8'd2);
    chk("cont_grant_p0", gid_a, 0);
    tick(5);
    chk("cont_cnt5", cnt_a, 5);
    chk("cont_done_p0", done_a, 1);
    chk("cont_done_id_p0", did_a, 0);
    tick(1);
    chk("cont_ready_p1", ia.req_ready, 2'b10);
    tick(1);
    drive(1, 0, 0, 8'd3);
    chk("cont_grant_p1", gid_a, 1);
    tick(3);
    chk("cont_cnt2", cnt_a, 2);
    chk("cont_done_id_p1", did_a, 1);
    tick(1);
    chk("cont_ready_p0b", ia.req_ready, 2'b01);
    tick(1);
    drive(0, 0, 1, 8'd2);
    tick(2);
    chk("cont_cnt4", cnt_a, 4);
    tick(2);

    // saturation: p1 down 4 from 0
    do_reset();
    drive(1, 1, 0, 8'd4);
    tick(1);
    drive(1, 0, 0, 8'd4);
    tick(4);
    chk("sat_cnt", cnt_a, 16'h0000);
    chk("sat_done", done_a, 1);
    chk("sat_done_id", did_a, 1);
    chk("sat_clipped", clip_a, 1);
    chk("wrap_cnt", cnt_b, 16'hFFFC);
    chk("wrap_done", done_b, 1);
    chk("wrap_done_id", did_b, 1);
    chk("wrap_clipped", clip_b, 0);
    tick(1);
    chk("wrap_busy_low", busy_b, 0);

    // zero length at 0x0010
    do_reset();
    drive(0, 1, 1, 8'd16);
    tick(1);
    drive(0, 0, 1, 8'd16);
    tick(16);
    chk("zl_pre_cnt", cnt_a, 16'h0010);
    tick(1);
    drive(0, 1, 1, 8'd0);
    tick(1);
    drive(0, 0, 1, 8'd0);
    chk("zl_done", done_a, 1);
    chk("zl_clipped", clip_a, 0);
    chk("zl_cnt", cnt_a, 16'h0010);
    tick(1);
    chk("zl_done_low", done_a, 0);
    chk("zl_busy_low", busy_a, 0);
    chk("zl_cnt_hold", cnt_a, 16'h0010);

    // reset in the middle of a p1 down-10 run
    drive(1, 1, 0, 8'd10);
    tick(1);
    drive(1, 0, 0, 8'd10);
    chk("mid_grant_p1", gid_a, 1);
    tick(3);
    chk("mid_cnt", cnt_a, 16'h000D);
    chk("mid_busy", busy_a, 1);
    begin
      int nd0;
      nd0 = ndone;
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_cnt", cnt_a, 0);
      chk("mid_rst_busy", busy_a, 0);
      chk("mid_rst_cnt_b", cnt_b, 0);
      tick(2);
      rst_n = 1'b1;
      drive(0, 1, 1, 8'd1);
      drive(1, 1, 1, 8'd1);
      #1 chk("mid_post_ready", ia.req_ready, 2'b01);
      tick(1);
      drive(0, 0, 1, 8'd1);
      drive(1, 0, 1, 8'd1);
      chk("mid_post_grant", gid_a, 0);
      chk("mid_post_grant_b", gid_b, 0);
      chk("mid_no_done", ndone, nd0);
      tick(1);
      chk("mid_post_done", done_a, 1);
      chk("mid_post_cnt", cnt_a, 1);
      tick(2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
